// File: rtl/tile_text_buffer_if.sv
// Bus bundle for tile_text_buffer: character writer port, registered read
// port, clear/scroll sweep controls and status. When TILE_CURSOR_EN is
// defined the cursor position inputs and cursor hit flag are added.
//
// Handshake: there is no valid/ready pair. wr_en_i, clr_i and scroll_i are
// single-cycle strobes sampled on the rising clock edge. A read address
// presented in cycle N is answered on dout_o (and cursor_o) in cycle N+1.
// done_o and wr_drop_o are one-cycle pulses.
interface tile_text_buffer_if #(
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5,
  parameter int CHAR_W = 7
);
  logic              wr_en_i;
  logic [COL_W-1:0]  col_w_i;
  logic [ROW_W-1:0]  row_w_i;
  logic [CHAR_W-1:0] din_i;
  logic [COL_W-1:0]  col_r_i;
  logic [ROW_W-1:0]  row_r_i;
  logic [CHAR_W-1:0] dout_o;
  logic [CHAR_W-1:0] fill_i;
  logic              clr_i;
  logic              scroll_i;
  logic              busy_o;
  logic              done_o;
  logic              wr_drop_o;
  logic [1:0]        dbg_state_o;
`ifdef TILE_CURSOR_EN
  logic [COL_W-1:0]  cursor_col_i;
  logic [ROW_W-1:0]  cursor_row_i;
  logic              cursor_o;
`endif

  modport master (
    output wr_en_i, col_w_i, row_w_i, din_i, col_r_i, row_r_i,
    output fill_i, clr_i, scroll_i,
`ifdef TILE_CURSOR_EN
    output cursor_col_i, cursor_row_i,
    input  cursor_o,
`endif
    input  dout_o, busy_o, done_o, wr_drop_o, dbg_state_o
  );

  modport slave (
    input  wr_en_i, col_w_i, row_w_i, din_i, col_r_i, row_r_i,
    input  fill_i, clr_i, scroll_i,
`ifdef TILE_CURSOR_EN
    input  cursor_col_i, cursor_row_i,
    output cursor_o,
`endif
    output dout_o, busy_o, done_o, wr_drop_o, dbg_state_o
  );
endinterface

// File: rtl/tile_text_buffer.sv
// tile_text_buffer: COLS x ROWS character tile RAM with logically addressed
// write port, registered read port, a clear/fill sweep engine and a one-row
// hardware scroll implemented as a rotating top-row offset.
// Optional feature macro: TILE_CURSOR_EN (cursor hit flag aligned with dout_o).
module tile_text_buffer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int CHAR_W = 7,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  tile_text_buffer_if.slave bus
);
  localparam int TILES  = COLS * ROWS;
  localparam int ADDR_W = $clog2(TILES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [ROW_W-1:0]  top_row;
  logic [ROW_W-1:0]  sw_row;
  logic [COL_W-1:0]  sw_col;
  logic              busy_q;
  logic              done_q;
  logic              wr_drop_q;
  logic [CHAR_W-1:0] dout_q;
  logic [CHAR_W-1:0] mem [TILES];

  logic              wr_in_range;
  logic              rd_in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CHAR_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] raddr;

  // Logical row -> physical row. The sum is formed one bit wider so it
  // cannot overflow before the modulo correction.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                input logic [ROW_W-1:0] top);
    logic [ROW_W:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= (ROW_W+1)'(ROWS)) sum = sum - (ROW_W+1)'(ROWS);
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [ROW_W-1:0] prow,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  // Range checks are one bit wider so COLS == 2^COL_W still works.
  assign wr_in_range = ({1'b0, bus.col_w_i} < (COL_W+1)'(COLS)) &&
                       ({1'b0, bus.row_w_i} < (ROW_W+1)'(ROWS));
  assign rd_in_range = ({1'b0, bus.col_r_i} < (COL_W+1)'(COLS)) &&
                       ({1'b0, bus.row_r_i} < (ROW_W+1)'(ROWS));
  assign raddr       = tile_addr(phys_row(bus.row_r_i, top_row), bus.col_r_i);

  // Single RAM write port: the sweep engine owns it while busy, the
  // character writer only gets it in IDLE.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state == CLEAR || state == SCROLL) begin
      mem_we    = 1'b1;
      mem_waddr = tile_addr(sw_row, sw_col);
      mem_wdata = bus.fill_i;
    end else if (state == IDLE && bus.wr_en_i && wr_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = tile_addr(phys_row(bus.row_w_i, top_row), bus.col_w_i);
      mem_wdata = bus.din_i;
    end
  end

  // Tile RAM write; blocked during reset so a reset mid-sweep stops filling.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read port; non-blocking read gives read-first on collisions.
  always_ff @(posedge clk_i) begin
    if (rst_i)            dout_q <= '0;
    else if (rd_in_range) dout_q <= mem[raddr];
    else                  dout_q <= '0;
  end

  // Flag writes that were not taken (out of range or engine not idle).
  always_ff @(posedge clk_i) begin
    if (rst_i) wr_drop_q <= 1'b0;
    else       wr_drop_q <= bus.wr_en_i && !(state == IDLE && wr_in_range);
  end

  // Sweep FSM: request decode, top-row rotation, sweep counters, status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      top_row <= '0;
      sw_row  <= '0;
      sw_col  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_i) begin
            state   <= CLEAR;
            top_row <= '0;
            sw_row  <= '0;
            sw_col  <= '0;
            busy_q  <= 1'b1;
          end else if (bus.scroll_i) begin
            state   <= SCROLL;
            sw_row  <= top_row;
            sw_col  <= '0;
            top_row <= (top_row == ROW_W'(ROWS-1)) ? '0 : top_row + 1'b1;
            busy_q  <= 1'b1;
          end
        end
        CLEAR, SCROLL: begin
          if (sw_col == COL_W'(COLS-1)) begin
            sw_col <= '0;
            if (state == SCROLL || sw_row == ROW_W'(ROWS-1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
            sw_row <= (sw_row == ROW_W'(ROWS-1)) ? '0 : sw_row + 1'b1;
          end else begin
            sw_col <= sw_col + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TILE_CURSOR_EN
  logic cursor_q;

  // Cursor hit on the logical read address, aligned with dout_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) cursor_q <= 1'b0;
    else       cursor_q <= rd_in_range && (bus.col_r_i == bus.cursor_col_i) &&
                           (bus.row_r_i == bus.cursor_row_i);
  end

  assign bus.cursor_o = cursor_q;
`endif

  assign bus.dout_o      = dout_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.wr_drop_o   = wr_drop_q;
  assign bus.dbg_state_o = state;
endmodule

// File: tb/tb_tile_text_buffer.sv
// Testbench for tile_text_buffer (80x30, 7-bit codes). Reads are checked by a
// scoreboard: the driver pushes the expected {cursor, data} into exp_q, a
// monitor pops and compares one cycle later. Screen contents are tracked in a
// logical-row model where scrolling physically shifts rows.
module tb_tile_text_buffer;
  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic clk;
  logic rst;
  tile_text_buffer_if #(.COL_W(7), .ROW_W(5), .CHAR_W(7)) bus ();

  tile_text_buffer #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(7), .COL_W(7), .ROW_W(5))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  string       tag_q[$];
  logic        rd_req = 1'b0;
  logic        rd_vld = 1'b0;
  logic [6:0]  scr [ROWS][COLS];
  int          cur_col = 127;
  int          cur_row = 31;

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- common helpers ----
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- driver tasks ----
  task automatic read_tile(input int c, input int r, input string tag);
    logic [6:0] d;
    logic       cb;
    d  = (c < COLS && r < ROWS) ? scr[r][c] : 7'h00;
    cb = (c < COLS && r < ROWS && c == cur_col && r == cur_row);
    bus.col_r_i = 7'(c);
    bus.row_r_i = 5'(r);
    rd_req = 1'b1;
    exp_q.push_back({cb, d});
    tag_q.push_back(tag);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic do_write(input int c, input int r, input logic [6:0] d, input logic exp_drop);
    bus.wr_en_i = 1'b1;
    bus.col_w_i = 7'(c);
    bus.row_w_i = 5'(r);
    bus.din_i   = d;
    tick();
    bus.wr_en_i = 1'b0;
    if (exp_drop) check("wr_drop_pulse", bus.wr_drop_o, 1);
    else begin
      if (c == 0 && r == 0) check("wr_drop_quiet", bus.wr_drop_o, 0);
      scr[r][c] = d;
    end
  endtask

  task automatic request(input logic clr, input logic scr_req, input logic [6:0] fill);
    bus.fill_i   = fill;
    bus.clr_i    = clr;
    bus.scroll_i = scr_req;
    tick();
    bus.clr_i    = 1'b0;
    bus.scroll_i = 1'b0;
  endtask

  // Counts busy cycles after a request edge; optionally injects a write and a
  // scroll request mid-sweep, then tries a scroll in the DONE cycle.
  task automatic run_sweep(input string name, input int exp_len, input int exp_state,
                           input int inject_at);
    int cnt;
    cnt = 0;
    check({name, "_state"}, bus.dbg_state_o, exp_state);
    while (bus.busy_o === 1'b1 && cnt < 5000) begin
      if (cnt == inject_at) begin
        bus.wr_en_i  = 1'b1;
        bus.col_w_i  = 7'd3;
        bus.row_w_i  = 5'd3;
        bus.din_i    = 7'h55;
        bus.scroll_i = 1'b1;
      end
      cnt++;
      tick();
      if (cnt == inject_at + 1) begin
        bus.wr_en_i  = 1'b0;
        bus.scroll_i = 1'b0;
        check({name, "_busy_drop"}, bus.wr_drop_o, 1);
      end
    end
    check({name, "_busy_cycles"}, cnt, exp_len);
    check({name, "_done_pulse"}, bus.done_o, 1);
    bus.scroll_i = 1'b1;
    tick();
    bus.scroll_i = 1'b0;
    check({name, "_done_low"}, bus.done_o, 0);
    check({name, "_done_req_ignored"}, bus.busy_o, 0);
  endtask

  task automatic model_fill(input logic [6:0] f);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = f;
  endtask

  task automatic model_scroll(input logic [6:0] f);
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
    for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = f;
  endtask

  task automatic readback(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) read_tile(c, r, tag);
  endtask

  // ---- scoreboard monitor ----
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    logic [7:0] e;
    string      t;
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read", bus.dout_o);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_dout"}, bus.dout_o, e[6:0]);
`ifdef TILE_CURSOR_EN
        check({t, "_cursor"}, bus.cursor_o, e[7]);
`endif
      end
    end
  end

  // ---- stimulus ----
  initial begin
    bus.wr_en_i  = 1'b0;
    bus.col_w_i  = '0;
    bus.row_w_i  = '0;
    bus.din_i    = '0;
    bus.col_r_i  = '0;
    bus.row_r_i  = '0;
    bus.fill_i   = '0;
    bus.clr_i    = 1'b0;
    bus.scroll_i = 1'b0;
`ifdef TILE_CURSOR_EN
    bus.cursor_col_i = 7'(cur_col);
    bus.cursor_row_i = 5'(cur_row);
`endif
    model_fill(7'h00);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_dout", bus.dout_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_wr_drop", bus.wr_drop_o, 0);
    check("rst_state", bus.dbg_state_o, 0);
`ifdef TILE_CURSOR_EN
    check("rst_cursor", bus.cursor_o, 0);
`endif

    // Corner tile write then read back one cycle later.
    do_write(79, 29, 7'h2A, 1'b0);
    check("wr_corner_busy", bus.busy_o, 0);
    read_tile(79, 29, "rd_corner");
    check("rd_corner_busy", bus.busy_o, 0);
    read_tile(0, 30, "rd_row30");
    read_tile(80, 0, "rd_col80");
    read_tile(127, 31, "rd_far");
    tick();

    // Full clear with a write and a scroll injected mid-sweep.
    request(1'b1, 1'b0, 7'h20);
    run_sweep("clear", 2400, 1, 100);
    model_fill(7'h20);
    do_write(80, 5, 7'h7F, 1'b1);
    do_write(3, 30, 7'h7E, 1'b1);
    readback("rd_clear");

    // Read-first collision on the same tile.
    bus.wr_en_i = 1'b1;
    bus.col_w_i = 7'd10;
    bus.row_w_i = 5'd10;
    bus.din_i   = 7'h05;
    read_tile(10, 10, "rd_collide_old");
    bus.wr_en_i = 1'b0;
    scr[10][10] = 7'h05;
    read_tile(10, 10, "rd_collide_new");

    // Row-coded screen, then one scroll with fill 0.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) do_write(c, r, 7'(r + 1), 1'b0);
    request(1'b0, 1'b1, 7'h00);
    run_sweep("scroll1", 80, 2, 10);
    model_scroll(7'h00);
    check("scroll1_row0_model", scr[0][0], 2);
    readback("rd_scroll1");

    // 29 more scrolls: top row wraps back to 0.
    for (int k = 0; k < 29; k++) begin
      request(1'b0, 1'b1, 7'(k + 8'h40));
      run_sweep("scrollN", 80, 2, -1);
      model_scroll(7'(k + 8'h40));
    end
    do_write(7, 0, 7'h61, 1'b0);
    readback("rd_scroll30");

    // Simultaneous clear and scroll: clear wins.
    request(1'b1, 1'b1, 7'h11);
    run_sweep("clr_scroll", 2400, 1, -1);
    model_fill(7'h11);
    for (int c = 0; c < COLS; c++) read_tile(c, 29, "rd_clr_scroll");

    // Reset in the middle of a clear, after tile 999 has been written.
    request(1'b1, 1'b0, 7'h33);
    repeat (1000) tick();
    check("mid_clear_busy", bus.busy_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", bus.busy_o, 0);
    check("rst_mid_done", bus.done_o, 0);
    check("rst_mid_state", bus.dbg_state_o, 0);
    begin
      int done_seen;
      done_seen = 0;
      repeat (5) begin
        tick();
        if (bus.done_o === 1'b1) done_seen++;
      end
      check("rst_mid_no_done", done_seen, 0);
    end
    for (int k = 0; k < 1000; k++) scr[k / COLS][k % COLS] = 7'h33;
    readback("rd_rst_mid");

`ifdef TILE_CURSOR_EN
    cur_col = 5;
    cur_row = 3;
    bus.cursor_col_i = 7'd5;
    bus.cursor_row_i = 5'd3;
    for (int c = 0; c < COLS; c++) read_tile(c, 3, "rd_cursor_row3");
    read_tile(80, 3, "rd_cursor_oor");
`endif

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_text_buffer.md
Name: tile_text_buffer

Overview:
- Parametrised successor to the fixed 80x30, 7-bit character tile buffer.
- Dual-port tile RAM with a logically addressed write port and a registered read port.
- Adds a hardware clear/fill engine and a hardware one-row scroll: a rotating top-row offset, with the vacated row filled automatically.
- Sits between the character writer and the VGA tile/glyph renderer.

Parameters:
- COLS, 80, tiles per row
- ROWS, 30, tile rows
- CHAR_W, 7, bits per tile code
- COL_W, 7, column address width (must satisfy 2^COL_W >= COLS)
- ROW_W, 5, row address width (must satisfy 2^ROW_W >= ROWS)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- wr_en_i  in  1  write strobe
- col_w_i  in  COL_W  write column (logical)
- row_w_i  in  ROW_W  write row (logical)
- din_i  in  CHAR_W  write data
- col_r_i  in  COL_W  read column (logical)
- row_r_i  in  ROW_W  read row (logical)
- dout_o  out  CHAR_W  read data, 1-cycle latency
- fill_i  in  CHAR_W  fill code used by clear and scroll
- clr_i  in  1  single-cycle pulse: fill the whole screen
- scroll_i  in  1  single-cycle pulse: scroll up one row
- busy_o  out  1  sweep engine active
- done_o  out  1  one-cycle pulse when a sweep completes
- wr_drop_o  out  1  one-cycle pulse when a write is discarded
- cursor_col_i  in  COL_W  cursor column (CURSOR_EN only)
- cursor_row_i  in  ROW_W  cursor row (CURSOR_EN only)
- cursor_o  out  1  cursor-hit flag, aligned with dout_o (CURSOR_EN only)

Behaviour:
- Reset values: dout_o=0, busy_o=0, done_o=0, wr_drop_o=0, cursor_o=0, top_row=0, state=IDLE. RAM contents are not reset.
- Address mapping: physical row = (logical row + top_row) mod ROWS, computed without overflow at ROW_W+1 bits. The column maps straight through.
- Reads:
  - dout_o is registered; it shows the data for the address presented at cycle N in cycle N+1.
  - If col_r_i >= COLS or row_r_i >= ROWS, dout_o=0.
  - Reads are always serviced, including while busy; they return the current RAM contents, which may be partially swept.
- Writes:
  - Taken on a clock edge when wr_en_i=1, state=IDLE and the address is in range.
  - An out-of-range write, or any write while busy_o=1, is discarded and wr_drop_o pulses the next cycle.
- Write/read collision: a write and a read to the same physical tile in the same cycle return the OLD data (read-first).
- FSM states and transitions:
  - IDLE: clr_i -> CLEAR. Otherwise scroll_i -> SCROLL. If both are asserted, clr_i wins and the scroll is dropped.
  - CLEAR:
    - top_row is set to 0 on entry.
    - The sweep counter writes fill_i to physical tiles 0..COLS*ROWS-1, row-major, one tile per cycle.
    - fill_i is sampled every cycle; it must be held stable by the user.
    - After the last tile -> DONE.
  - SCROLL:
    - On entry, vacated row = old top_row, and top_row <= (top_row+1) mod ROWS.
    - The engine writes fill_i to the COLS tiles of the vacated row, now logical row ROWS-1.
    - After the last tile -> DONE.
  - DONE: done_o=1 for one cycle -> IDLE. A new request in this cycle is ignored.
- Timing: busy_o rises the cycle after the request edge and stays high for exactly COLS*ROWS cycles (CLEAR) or COLS cycles (SCROLL). done_o pulses in the cycle after busy_o falls.
- Requests (clr_i, scroll_i) arriving while busy_o=1 or in DONE are ignored. They are not queued.
- Wrap-around: top_row wraps from ROWS-1 to 0. The sweep counters wrap the column at COLS-1 and the row at ROWS-1.
- Reset mid-sweep: state returns to IDLE and top_row to 0, with no done_o. Tiles already filled keep the fill value.

Optional Feature:
- Macro TILE_CURSOR_EN.
- Defined:
  - Adds cursor_col_i, cursor_row_i and cursor_o.
  - cursor_o=1 in the cycle dout_o is valid if the registered read address equals the cursor position (logical coordinates, in range).
  - If that address is out of range, cursor_o=0.
- Undefined: the ports are absent and no comparator logic is generated.

Test Plan:
- Reset, write (col 79, row 29, din 0x2A), read the same address next cycle -> dout_o=0x2A exactly one cycle after the read address; busy_o=0 throughout.
- Out-of-range write at col 80 -> wr_drop_o pulse, RAM unchanged. Read at row 30 -> dout_o=0.
- clr_i with fill_i=0x20 -> busy_o high for 2400 cycles, done_o pulses once. A full readback returns 0x20 everywhere. A write issued mid-sweep is dropped with wr_drop_o.
- Write rows 0..29 with code = row+1, then scroll_i with fill 0 -> busy_o for 80 cycles. Afterwards logical row r reads r+2 for r<29 and row 29 reads 0. Repeat 30 scrolls -> top_row wraps to 0.
- Assert clr_i and scroll_i in the same cycle -> CLEAR only (2400 busy cycles). Assert rst_i mid-CLEAR at tile 1000 -> tiles 0..999 hold the fill value, tile 1000 onward is unchanged, no done_o.
- With TILE_CURSOR_EN defined, cursor at (5,3), sweep reads across row 3 -> cursor_o high only in the cycle dout_o shows tile (5,3).
